ro_puf_ctrl: RTL
================

RO_PUF_CTRL -- requirements
Module: ro_puf_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_RO, default 16, giving the number of ring oscillators controlled (power of 2, at least 4).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the edge-counter width.
REQ-003 The block SHALL have parameter WINDOW, default 4096, giving the count-window length in clk cycles (at least 1).
REQ-004 The block SHALL have parameter SETTLE, default 8, giving the cycles between RO enable and the start of counting (at least 2).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: a 1-cycle request to evaluate one challenge.
REQ-008 The block SHALL have port chal_a, input, clog2(NUM_RO) bits: index of the first RO.
REQ-009 The block SHALL have port chal_b, input, clog2(NUM_RO) bits: index of the second RO.
REQ-010 The block SHALL have port ro_out, input, NUM_RO bits: the asynchronous RO outputs.
REQ-011 The block SHALL have port ro_en, output, NUM_RO bits: per-RO enable.
REQ-012 The block SHALL have port busy, output, 1 bit: high from acceptance of start until done.
REQ-013 The block SHALL have port done, output, 1 bit: a 1-cycle pulse when the result is valid.
REQ-014 The block SHALL have port resp, output, 1 bit: the response bit, 1 when cnt_a > cnt_b.
REQ-015 The block SHALL have port cnt_a, output, CNT_W bits: the final count of RO a.
REQ-016 The block SHALL have port cnt_b, output, CNT_W bits: the final count of RO b.
REQ-017 The block SHALL have port err, output, 1 bit: set when chal_a == chal_b.

Function
REQ-018 The state machine SHALL have the states IDLE, SETTLE, COUNT, CMP and DONE.
REQ-019 In IDLE, start=1 SHALL latch chal_a and chal_b and clear both counters; the next state SHALL be SETTLE, or DONE directly with err=1 and resp=0 if the indices are equal.
REQ-020 ro_en SHALL be one-hot-pair (bits a and b only) in SETTLE and COUNT, and all-zero in every other state.
REQ-021 SETTLE SHALL last exactly SETTLE cycles, after which the FSM SHALL go to COUNT.
REQ-022 Each selected ro_out bit SHALL pass through a 2-flop synchronizer followed by a rising-edge detector; each detected edge SHALL increment its counter during COUNT only.
REQ-023 COUNT SHALL last exactly WINDOW cycles, after which the FSM SHALL go to CMP.
REQ-024 The counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-025 CMP SHALL register resp = (cnt_a > cnt_b), with ties giving resp=0, and SHALL go to DONE.
REQ-026 DONE SHALL assert done for one cycle and return to IDLE.
REQ-027 busy SHALL be high in SETTLE, COUNT, CMP and DONE.
REQ-028 start while busy SHALL be ignored.
REQ-029 A start in the same cycle as the done pulse SHALL be ignored; it is accepted only in IDLE.
REQ-030 resp, cnt_a, cnt_b and err SHALL hold their values until the next accepted start.
REQ-031 Latency from start to done SHALL be SETTLE+WINDOW+2 cycles (err case: 1 cycle).

Reset
REQ-032 On rst=1 at a clk edge, the block SHALL enter IDLE and clear ro_en, busy, done, resp, err, cnt_a, cnt_b and the synchronizers to 0.
REQ-033 rst SHALL take priority over start.
REQ-034 rst mid-operation SHALL abort the evaluation with no done pulse, and ro_en SHALL be 0 on the cycle after the reset edge.

Configuration
REQ-035 The macro RO_PUF_CTRL_TIE_FLAG_EN, when defined, SHALL add output port tie (1 bit), set in CMP when cnt_a == cnt_b and cleared on start or rst.
REQ-036 With RO_PUF_CTRL_TIE_FLAG_EN undefined, the tie port and its logic SHALL be absent, and resp SHALL behave identically in both builds.

Structure
REQ-037 Package ro_puf_pkg SHALL hold the FSM state enum (ro_puf_state_t) and the default parameter constants.
REQ-038 A sub-module ro_edge_counter SHALL implement synchronizer, edge detect and saturating counter, and SHALL be instantiated twice (a and b).

Verification
REQ-039 Model RO a at a clk/6 toggle rate and RO b at clk/10, with chal_a=3 and chal_b=7, WINDOW=600; the bench SHALL see resp=1, cnt_a=100±1, cnt_b=60±1, and done exactly SETTLE+WINDOW+2 cycles after start.
REQ-040 With the same models and the pair swapped, the bench SHALL see resp=0.
REQ-041 With equal-rate ROs, the bench SHALL see resp=0, tie=1 when the macro is defined, and no tie port otherwise.
REQ-042 With chal_a=chal_b=5, the bench SHALL see err=1, resp=0, done one cycle after start, and ro_en held at 0 throughout.
REQ-043 With CNT_W=4 and a fast RO, the bench SHALL see cnt_a saturate at 15 with no wrap.
REQ-044 rst asserted mid-COUNT SHALL give ro_en=0 the next cycle and no done, and a subsequent start SHALL complete normally.
REQ-045 start pulses while busy SHALL cause no change to the latched challenge or timing.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// Shared FSM state type and default configuration for the ring-oscillator PUF controller.
package ro_puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_CMP,
        ST_DONE
    } ro_puf_state_t;

    localparam int unsigned DEF_NUM_RO = 16;
    localparam int unsigned DEF_CNT_W  = 16;
    localparam int unsigned DEF_WINDOW = 4096;
    localparam int unsigned DEF_SETTLE = 8;

endpackage

// File: rtl/ro_edge_counter.sv
// Two-flop synchronizer, rising-edge detector and saturating edge counter for one RO.
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_cnt_en,
    input  logic             i_ro,
    output logic [CNT_W-1:0] o_cnt
);

    logic [1:0]       r_sync;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             w_rise;

    assign w_rise = r_sync[1] & ~r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_ro};
            r_prev <= r_sync[1];
        end
    end

    // Counter holds at all-ones once reached; edges outside the count window are dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_cnt_en && w_rise && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF challenge controller: enables a pair of ROs, counts edges, compares.
// Optional tie output is enabled by defining RO_PUF_CTRL_TIE_FLAG_EN.
module ro_puf_ctrl
    import ro_puf_pkg::*;
#(
    parameter int unsigned NUM_RO = DEF_NUM_RO,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned WINDOW = DEF_WINDOW,
    parameter int unsigned SETTLE = DEF_SETTLE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [$clog2(NUM_RO)-1:0] chal_a,
    input  logic [$clog2(NUM_RO)-1:0] chal_b,
    input  logic [NUM_RO-1:0]         ro_out,
    output logic [NUM_RO-1:0]         ro_en,
    output logic                      busy,
    output logic                      done,
    output logic                      resp,
    output logic [CNT_W-1:0]          cnt_a,
    output logic [CNT_W-1:0]          cnt_b,
    output logic                      err
`ifdef RO_PUF_CTRL_TIE_FLAG_EN
    ,
    output logic                      tie
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_RO);
    localparam int unsigned TMR_W = $clog2(((SETTLE > WINDOW) ? SETTLE : WINDOW) + 1);

    ro_puf_state_t     r_state;
    logic [TMR_W-1:0]  r_timer;
    logic [IDX_W-1:0]  r_idx_a;
    logic [IDX_W-1:0]  r_idx_b;
    logic [NUM_RO-1:0] r_ro_en;
    logic              r_busy;
    logic              r_done;
    logic              r_resp;
    logic              r_err;

    logic              w_accept;
    logic              w_cnt_en;
    logic              w_ro_a;
    logic              w_ro_b;
    logic [NUM_RO-1:0] w_pair;
    logic [CNT_W-1:0]  w_cnt_a;
    logic [CNT_W-1:0]  w_cnt_b;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_cnt_en = (r_state == ST_COUNT);
    assign w_pair   = (NUM_RO'(1) << chal_a) | (NUM_RO'(1) << chal_b);

    // Index is latched before SETTLE, so the mux output is stable by the time counting starts.
    assign w_ro_a = ro_out[r_idx_a];
    assign w_ro_b = ro_out[r_idx_b];

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clr    (w_accept),
        .i_cnt_en (w_cnt_en),
        .i_ro     (w_ro_a),
        .o_cnt    (w_cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clr    (w_accept),
        .i_cnt_en (w_cnt_en),
        .i_ro     (w_ro_b),
        .o_cnt    (w_cnt_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_idx_a <= '0;
            r_idx_b <= '0;
            r_ro_en <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_resp  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx_a <= chal_a;
                        r_idx_b <= chal_b;
                        r_resp  <= 1'b0;
                        r_busy  <= 1'b1;
                        if (chal_a == chal_b) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_ro_en <= w_pair;
                            r_timer <= TMR_W'(SETTLE - 1);
                            r_state <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (r_timer == '0) begin
                        r_timer <= TMR_W'(WINDOW - 1);
                        r_state <= ST_COUNT;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                ST_COUNT: begin
                    if (r_timer == '0) begin
                        r_ro_en <= '0;
                        r_state <= ST_CMP;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                ST_CMP: begin
                    r_resp  <= (w_cnt_a > w_cnt_b);
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ro_en <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RO_PUF_CTRL_TIE_FLAG_EN
    logic r_tie;

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_tie <= 1'b0;
        end else if (r_state == ST_CMP) begin
            r_tie <= (w_cnt_a == w_cnt_b);
        end
    end

    assign tie = r_tie;
`endif

    assign ro_en = r_ro_en;
    assign busy  = r_busy;
    assign done  = r_done;
    assign resp  = r_resp;
    assign err   = r_err;
    assign cnt_a = w_cnt_a;
    assign cnt_b = w_cnt_b;

endmodule
